// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler.
// Baud-rate codes, scheduler states and the reset rate.
package uart_pkg;

    typedef enum logic [1:0] {
        BAUD24  = 2'b00,
        BAUD48  = 2'b01,
        BAUD96  = 2'b10,
        BAUD192 = 2'b11
    } baud_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LOAD,
        S_START,
        S_ACK,
        S_DRAIN
    } sched_state_e;

    localparam baud_e BAUD_RESET = BAUD96;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr_i,
// wrapping modulo NUM_REQ; gnt_o is one-hot or all zeros.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o
);

    logic found;
    int   idx;

    // Scan from the pointer and keep the first requester found
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Tx and baud generator among NUM_REQ
// packet requesters, round-robin, one whole packet per grant.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2605
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ*2-1:0] req_baud,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 grant_valid,
    output logic [1:0]           baud_rate,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    sched_state_e state_q, state_d;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               gv_q, gv_d;
    baud_e              baud_q, baud_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q, last_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      pick_idx;
    logic [PW-1:0]      own_idx;
    logic [PW-1:0]      next_ptr;
    baud_e              pick_baud;
    logic               any_req;
    logic               hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (arb_gnt)
    );

    // One-hot to index for the new pick and the current owner
    always_comb begin
        pick_idx = '0;
        own_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) pick_idx = PW'(i);
            if (grant_q[i]) own_idx  = PW'(i);
        end
    end

    assign any_req   = |req_valid;
    assign pick_baud = baud_e'(req_baud[{pick_idx, 1'b0} +: 2]);
    assign hs        = (state_q == S_LOAD) && |(grant_q & req_valid);
    assign next_ptr  = (own_idx == PW'(NUM_REQ - 1)) ? '0 : own_idx + 1'b1;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req)
                    state_d = (pick_baud != baud_q) ? S_SETTLE : S_LOAD;
            end
            S_SETTLE: if (cnt_q == '0) state_d = S_LOAD;
            S_LOAD:   if (hs) state_d = S_START;
            S_START:  state_d = S_ACK;
            S_ACK:    if (tx_busy) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) state_d = last_q ? S_IDLE : S_LOAD;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        gv_d       = gv_q;
        baud_d     = baud_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        tx_start_d = (state_d == S_START);
        req_ready  = (state_q == S_LOAD) ? (grant_q & req_valid) : '0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = arb_gnt;
                    gv_d    = 1'b1;
                    if (pick_baud != baud_q) begin
                        baud_d = pick_baud;
                        cnt_d  = SETTLE_LOAD;
                    end
                end
            end
            S_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            S_LOAD: begin
                if (hs) begin
                    tx_data_d = req_data[{own_idx, 3'b000} +: 8];
                    last_d    = req_last[own_idx];
                end
            end
            S_DRAIN: begin
                if (!tx_busy && last_q) begin
                    grant_d  = '0;
                    gv_d     = 1'b0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            gv_q       <= 1'b0;
            baud_q     <= BAUD_RESET;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            last_q     <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            gv_q       <= gv_d;
            baud_q     <= baud_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign baud_rate   = baud_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small
// behavioural UART Tx busy model.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int SC = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N*2-1:0] req_baud = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   baud_rate;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_busy;

    int n_run = 0;
    int n_fail = 0;
    int busy_cnt;
    int baud_glitch = 0;
    logic [1:0] baud_prev = 2'b10;
    logic [3:0] exp_q [5];

    uart_tx_scheduler #(
        .NUM_REQ       (N),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_baud    (req_baud),
        .req_ready   (req_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .baud_rate   (baud_rate),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy)
    );

    always #5 clock = ~clock;

    // UART Tx model: busy for 6 cycles after each start pulse
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)            busy_cnt <= 0;
        else if (tx_start)       busy_cnt <= 6;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Rate must never move while a frame is shifting
    always @(negedge clock) begin
        if (reset_n && tx_busy && baud_rate != baud_prev)
            baud_glitch++;
        baud_prev = baud_rate;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_gv"}, 32'(grant_valid), 32'h0);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_start"}, 32'(tx_start), 32'h0);
        check({tag, "_data"}, 32'(tx_data), 32'h0);
        check({tag, "_baud"}, 32'(baud_rate), 32'h2);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!tx_busy && c < 50) begin tick(); c++; end
        check({tag, "_busy_rise_to"}, 32'(c < 50), 32'h1);
        c = 0;
        while (tx_busy && c < 50) begin tick(); c++; end
        check({tag, "_busy_fall_to"}, 32'(c < 50), 32'h1);
    endtask

    task automatic wait_ready(input int i, input string tag);
        int c = 0;
        while (!req_ready[i] && c < 100) begin tick(); c++; end
        check({tag, "_ready_to"}, 32'(c < 100), 32'h1);
    endtask

    task automatic run_rr(input string tag, input logic [3:0] mask,
                          input int n);
        logic [3:0] got [5];
        int   cnt = 0;
        int   c = 0;
        logic prev = 1'b0;
        req_valid = mask;
        while (cnt < n && c < 500) begin
            tick();
            c++;
            if (grant_valid && !prev) begin
                got[cnt] = grant;
                check({tag, "_rdy"}, 32'(req_ready), 32'(grant));
                cnt++;
            end
            prev = grant_valid;
        end
        check({tag, "_count"}, 32'(cnt), 32'(n));
        tick();
        req_valid = '0;
        wait_done(tag);
        tick();
        check({tag, "_end_gv"}, 32'(grant_valid), 32'h0);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_g%0d", tag, i), 32'(got[i]),
                  32'(exp_q[i]));
    endtask

    logic [7:0] mb [3];
    int st;

    initial begin
        // Reset values and a single-byte packet, no rate change
        do_reset();
        check_reset("rst0");
        req_data[15:8] = 8'hA5;
        req_last[1]    = 1'b1;
        req_baud[3:2]  = 2'b10;
        req_valid[1]   = 1'b1;
        tick();
        check("t1_grant", 32'(grant), 32'h2);
        check("t1_gv", 32'(grant_valid), 32'h1);
        check("t1_ready", 32'(req_ready), 32'h2);
        check("t1_baud", 32'(baud_rate), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        check("t1_start", 32'(tx_start), 32'h1);
        check("t1_data", 32'(tx_data), 32'hA5);
        tick();
        check("t1_start_pulse", 32'(tx_start), 32'h0);
        wait_done("t1");
        check("t1_gv_at_fall", 32'(grant_valid), 32'h1);
        tick();
        check("t1_gv_after", 32'(grant_valid), 32'h0);
        check("t1_grant_after", 32'(grant), 32'h0);

        // Rate change: settle interval before the first byte
        req_data[7:0] = 8'h3C;
        req_last[0]   = 1'b1;
        req_baud[1:0] = 2'b11;
        req_valid[0]  = 1'b1;
        tick();
        check("t2_baud", 32'(baud_rate), 32'h3);
        check("t2_grant", 32'(grant), 32'h1);
        check("t2_ready0", 32'(req_ready), 32'h0);
        st = 0;
        while (!req_ready[0] && st < 20) begin st++; tick(); end
        check("t2_settle_len", 32'(st), 32'(SC));
        tick();
        req_valid[0] = 1'b0;
        check("t2_start", 32'(tx_start), 32'h1);
        check("t2_data", 32'(tx_data), 32'h3C);
        wait_done("t2");
        tick();
        check("t2_gv_after", 32'(grant_valid), 32'h0);
        check("t2_baud_hold", 32'(baud_rate), 32'h3);

        // Round robin between two, then among all four
        do_reset();
        check_reset("rst1");
        req_baud = 8'hAA;
        req_last = 4'hF;
        exp_q = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0000};
        run_rr("rr2", 4'b0101, 4);
        do_reset();
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        run_rr("rr4", 4'b1111, 5);

        // Multi-byte packet from req3 while req0 waits
        mb = '{8'h11, 8'h22, 8'h33};
        req_baud       = 8'hAA;
        req_last       = 4'b0001;
        req_data[7:0]  = 8'h99;
        req_valid[0]   = 1'b1;
        req_valid[3]   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_data[31:24] = mb[i];
            req_last[3]     = (i == 2);
            wait_ready(3, "mb");
            check($sformatf("mb_grant%0d", i), 32'(grant), 32'h8);
            check($sformatf("mb_ready%0d", i), 32'(req_ready), 32'h8);
            tick();
            if (i == 0) req_baud[7:6] = 2'b01;
            if (i == 2) req_valid[3] = 1'b0;
            check($sformatf("mb_start%0d", i), 32'(tx_start), 32'h1);
            check($sformatf("mb_data%0d", i), 32'(tx_data), 32'(mb[i]));
            check($sformatf("mb_baud%0d", i), 32'(baud_rate), 32'h2);
            wait_done("mb");
        end
        check("mb_hold", 32'(grant), 32'h8);
        tick();
        check("mb_gv_drop", 32'(grant_valid), 32'h0);
        tick();
        check("mb_next_grant", 32'(grant), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        check("mb_r0_data", 32'(tx_data), 32'h99);
        wait_done("mb_r0");
        tick();
        check("mb_r0_gv", 32'(grant_valid), 32'h0);

        // Stall in LOAD, then reset while draining
        req_baud[5:4]   = 2'b01;
        req_last[2]     = 1'b0;
        req_data[23:16] = 8'h5A;
        req_valid[2]    = 1'b1;
        tick();
        wait_ready(2, "st");
        req_valid[2] = 1'b0;
        st = 0;
        repeat (10) begin
            tick();
            if (tx_start) st++;
            if (grant != 4'b0100) st++;
        end
        check("st_stall", 32'(st), 32'h0);
        check("st_gv", 32'(grant_valid), 32'h1);
        req_valid[2] = 1'b1;
        tick();
        check("st_start", 32'(tx_start), 32'h1);
        check("st_data", 32'(tx_data), 32'h5A);
        st = 0;
        while (!tx_busy && st < 50) begin tick(); st++; end
        check("st_busy_to", 32'(st < 50), 32'h1);
        tick();
        check("st_baud_pre", 32'(baud_rate), 32'h1);
        #2 reset_n = 1'b0;
        #1 check_reset("rst_mid");
        req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_start", 32'(tx_start), 32'h0);
        check("post_rst_gv", 32'(grant_valid), 32'h0);

        check("baud_stable_busy", 32'(baud_glitch), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
